// File: rtl/led_cnt_multi.sv
// led_cnt_multi: NUM_CH independent LED channels driven from one shared
// prescaler on clk100. Each channel has a programmable tick divider, a mode
// (off / blink / pulse / solid), a saturating event counter and a sticky
// interrupt flag.
//
// Ports:
//   clk100     system clock
//   rst_n      asynchronous active-low reset
//   wren_i     one-cycle configuration write strobe
//   ch_sel_i   channel targeted by wren_i (values >= NUM_CH are ignored)
//   div_i      divider value written on wren_i (event period = div_i+1 ticks)
//   mode_i     mode written on wren_i: 00 off, 01 blink, 10 pulse, 11 solid
//   int_clr_i  per-channel clear of led_int_o and the channel's event count
//   int_cnt_o  event counters, channel k at [k*CNT_W +: CNT_W]
//   led_int_o  sticky per-channel event flag
//   led_o      LED drive
module led_cnt_multi #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DIV_W    = 12,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned PRESCALE = 100000,
  parameter int unsigned DIV_RST  = 499,
  parameter int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk100,
  input  logic                    rst_n,
  input  logic                    wren_i,
  input  logic [CH_W-1:0]         ch_sel_i,
  input  logic [DIV_W-1:0]        div_i,
  input  logic [1:0]              mode_i,
  input  logic [NUM_CH-1:0]       int_clr_i,
  output logic [NUM_CH*CNT_W-1:0] int_cnt_o,
  output logic [NUM_CH-1:0]       led_int_o,
  output logic [NUM_CH-1:0]       led_o
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_BLINK = 2'b01,
    MODE_PULSE = 2'b10,
    MODE_SOLID = 2'b11
  } mode_e;

  logic [PS_W-1:0]  presc;
  logic             tick;

  logic [DIV_W-1:0] div_reg  [NUM_CH];
  mode_e            mode_reg [NUM_CH];
  logic [DIV_W-1:0] cnt      [NUM_CH];
  logic [CNT_W-1:0] int_cnt  [NUM_CH];

  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] evt;

  // Shared prescaler: free-running 0..PRESCALE-1, never touched by writes.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PS_W'(1);
    end
  end

  assign tick = (presc == PS_W'(PRESCALE - 1));

  // A write to a channel suppresses any event that channel would raise on
  // the same tick; the write restarts the period instead.
  always_comb begin
    wr_hit = '0;
    evt    = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      wr_hit[k] = wren_i && (ch_sel_i == CH_W'(k));
      evt[k]    = tick && !wr_hit[k] && (mode_reg[k] != MODE_OFF) &&
                  (cnt[k] == div_reg[k]);
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        div_reg[k]  <= DIV_W'(DIV_RST);
        mode_reg[k] <= MODE_BLINK;
        cnt[k]      <= '0;
        int_cnt[k]  <= '0;
      end
      led_int_o <= '0;
      led_o     <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (wr_hit[k]) begin
          div_reg[k]  <= div_i;
          mode_reg[k] <= mode_e'(mode_i);
          cnt[k]      <= '0;
          if (mode_e'(mode_i) == MODE_OFF) begin
            led_o[k] <= 1'b0;
          end
        end else if (tick && (mode_reg[k] != MODE_OFF)) begin
          cnt[k] <= evt[k] ? '0 : cnt[k] + DIV_W'(1);
          // Pulse: the LED mirrors "counter is at 0 after this tick", which
          // is exactly the event condition, so it is refreshed on each tick.
          case (mode_reg[k])
            MODE_BLINK: if (evt[k]) led_o[k] <= ~led_o[k];
            MODE_PULSE: led_o[k] <= evt[k];
            MODE_SOLID: led_o[k] <= 1'b1;
            default:    ;
          endcase
        end

        // A clear coinciding with an event keeps that event.
        if (int_clr_i[k]) begin
          int_cnt[k]   <= evt[k] ? CNT_W'(1) : '0;
          led_int_o[k] <= evt[k];
        end else if (evt[k]) begin
          if (int_cnt[k] != '1) begin
            int_cnt[k] <= int_cnt[k] + CNT_W'(1);
          end
          led_int_o[k] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    int_cnt_o = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      int_cnt_o[k*CNT_W +: CNT_W] = int_cnt[k];
    end
  end

endmodule

// File: tb/tb_led_cnt_multi.sv
module tb_led_cnt_multi;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int PS  = 4;
  localparam int CHW = 3;
  localparam int DW  = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wren = 1'b0;
  logic [CHW-1:0]  ch_sel = '0;
  logic [DW-1:0]   div = '0;
  logic [1:0]      mode = '0;
  logic [NCH-1:0]  clr = '0;
  logic [NCH*CW-1:0] int_cnt;
  logic [NCH-1:0]  led_int;
  logic [NCH-1:0]  led;

  led_cnt_multi #(
    .NUM_CH  (NCH),
    .DIV_W   (DW),
    .CNT_W   (CW),
    .PRESCALE(PS),
    .DIV_RST (499),
    .CH_W    (CHW)
  ) dut (
    .clk100   (clk),
    .rst_n    (rst_n),
    .wren_i   (wren),
    .ch_sel_i (ch_sel),
    .div_i    (div),
    .mode_i   (mode),
    .int_clr_i(clr),
    .int_cnt_o(int_cnt),
    .led_int_o(led_int),
    .led_o    (led)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int nvec  = 0;
  int nfail = 0;

  // Reference model: each channel tracks how many ticks have elapsed since
  // its last write; an event falls on every multiple of (div+1) ticks.
  int cyc;
  int m_n    [NCH];
  int m_div  [NCH];
  int m_mode [NCH];
  int m_icnt [NCH];
  bit m_led  [NCH];
  bit m_iflag[NCH];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int k = 0; k < NCH; k++) begin
      m_n[k] = 0; m_div[k] = 499; m_mode[k] = 1;
      m_icnt[k] = 0; m_led[k] = 1'b0; m_iflag[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit tick;
    bit evt;
    tick = ((cyc % PS) == PS - 1);
    for (int k = 0; k < NCH; k++) begin
      evt = 1'b0;
      if (wren && (int'(ch_sel) == k)) begin
        m_div[k] = int'(div); m_mode[k] = int'(mode); m_n[k] = 0;
        if (mode == 2'b00) m_led[k] = 1'b0;
      end else if (tick && m_mode[k] != 0) begin
        m_n[k]++;
        evt = ((m_n[k] % (m_div[k] + 1)) == 0);
        case (m_mode[k])
          1: if (evt) m_led[k] = ~m_led[k];
          2: m_led[k] = evt;
          default: m_led[k] = 1'b1;
        endcase
      end
      if (clr[k]) begin
        m_icnt[k] = evt ? 1 : 0;
        m_iflag[k] = evt;
      end else if (evt) begin
        if (m_icnt[k] < 255) m_icnt[k]++;
        m_iflag[k] = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    logic [31:0] e_led, e_int, e_cnt;
    e_led = '0; e_int = '0; e_cnt = '0;
    for (int k = 0; k < NCH; k++) begin
      e_led[k] = m_led[k];
      e_int[k] = m_iflag[k];
      e_cnt[k*CW +: CW] = m_icnt[k][CW-1:0];
    end
    check("led_o", 32'(led), e_led);
    check("led_int_o", 32'(led_int), e_int);
    check("int_cnt_o", 32'(int_cnt), e_cnt);
  endtask

  // Inputs change only at posedge+1, so the model sees the same values the
  // DUT sampled at the edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic strobe(input bit w, input int ch, input int d, input int md, input logic [NCH-1:0] c);
    wren = w; ch_sel = CHW'(ch); div = DW'(d); mode = 2'(md); clr = c;
    cycle();
    wren = 1'b0; clr = '0;
  endtask

  typedef struct {
    int           idle_n;
    bit           wr;
    int           ch;
    int           dv;
    int           md;
    logic [3:0]   c;
    int           post_n;
    logic [3:0]   e_led;
    logic [3:0]   e_int;
    logic [31:0]  e_cnt;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int hi, t, c0, budget;
    bit ok, l0, prev, found;

    // Edge numbers counted from reset release: a tick is sampled on every
    // 4th edge, so the default div 499 gives the first event on edge 2000.
    tbl[0] = '{1998, 1'b0, 0, 0, 0, 4'b0000, 0,  4'h0,    4'h0,    32'h0000_0000};
    tbl[1] = '{0,    1'b0, 0, 0, 0, 4'b0000, 0,  4'hF,    4'hF,    32'h0101_0101};
    tbl[2] = '{0,    1'b1, 1, 2, 1, 4'b0010, 59, 4'b1101, 4'hF,    32'h0101_0501};
    tbl[3] = '{11,   1'b0, 0, 0, 0, 4'b0010, 0,  4'hF,    4'hF,    32'h0101_0101};
    tbl[4] = '{0,    1'b0, 0, 0, 0, 4'b0010, 0,  4'hF,    4'b1101, 32'h0101_0001};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_led", 32'(led), 32'h0);
    check("rst_int", 32'(led_int), 32'h0);
    check("rst_cnt", 32'(int_cnt), 32'h0);
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 5; i++) begin
      idle(tbl[i].idle_n);
      strobe(tbl[i].wr, tbl[i].ch, tbl[i].dv, tbl[i].md, tbl[i].c);
      idle(tbl[i].post_n);
      check($sformatf("tbl%0d_led", i), 32'(led), 32'(tbl[i].e_led));
      check($sformatf("tbl%0d_int", i), 32'(led_int), 32'(tbl[i].e_int));
      check($sformatf("tbl%0d_cnt", i), 32'(int_cnt), tbl[i].e_cnt);
    end

    // Pulse mode on ch2: high 4 of every 16 clocks.
    strobe(1'b1, 2, 3, 2, 4'b0);
    idle(16);
    hi = 0;
    repeat (32) begin
      cycle();
      if (led[2]) hi++;
    end
    check("pulse_duty", 32'(hi), 32'd8);

    // Solid: constant 1 after the first tick, events still counted.
    strobe(1'b1, 2, 3, 3, 4'b0);
    c0 = m_icnt[2];
    idle(4);
    ok = 1'b1;
    repeat (32) begin
      cycle();
      if (!led[2]) ok = 1'b0;
    end
    check("solid_led", 32'(ok), 32'd1);
    check("solid_events", 32'(int'(int_cnt[23:16]) > c0), 32'd1);

    // Off: LED cleared on the next cycle, count frozen.
    strobe(1'b1, 2, 3, 0, 4'b0);
    check("off_led_next", 32'(led[2]), 32'd0);
    c0 = m_icnt[2];
    idle(40);
    check("off_frozen", 32'(int_cnt[23:16]), 32'(c0));

    // div=0 on ch3: event every tick, count saturates.
    strobe(1'b1, 3, 0, 1, 4'b0);
    idle(1200);
    check("sat_cnt", 32'(int_cnt[31:24]), 32'd255);
    prev = led[3];
    t = 0;
    repeat (40) begin
      cycle();
      if (led[3] != prev) t++;
      prev = led[3];
    end
    check("div0_toggles", 32'(t), 32'd10);

    // Write to ch1 on the edge where its event would land.
    budget = 200;
    found = 1'b0;
    while (budget > 0 && !found) begin
      if (((cyc % PS) == PS - 1) && m_mode[1] != 0 &&
          (((m_n[1] + 1) % (m_div[1] + 1)) == 0))
        found = 1'b1;
      else begin
        cycle();
        budget--;
      end
    end
    check("collision_found", 32'(found), 32'd1);
    c0 = m_icnt[1];
    l0 = m_led[1];
    strobe(1'b1, 1, 2, 1, 4'b0);
    check("wr_wins_cnt", 32'(int_cnt[15:8]), 32'(c0));
    check("wr_wins_led", 32'(led[1]), 32'(l0));
    idle(11);
    check("restart_hold", 32'(int_cnt[15:8]), 32'(c0));
    cycle();
    check("restart_evt", 32'(int_cnt[15:8]), 32'((c0 < 255) ? c0 + 1 : 255));

    // Out-of-range channel select: nothing changes.
    strobe(1'b1, 5, 0, 0, 4'b0);
    idle(20);

    // Randomised traffic.
    repeat (3000) begin
      if ($urandom_range(15) == 0) begin
        wren = 1'b1;
        ch_sel = CHW'($urandom_range(5));
        div = DW'($urandom_range(7));
        mode = 2'($urandom_range(3));
      end
      for (int k = 0; k < NCH; k++) clr[k] = ($urandom_range(31) == 0);
      cycle();
      wren = 1'b0;
      clr = '0;
    end

    // Asynchronous reset between clock edges.
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_led", 32'(led), 32'h0);
    check("async_rst_int", 32'(led_int), 32'h0);
    check("async_rst_cnt", 32'(int_cnt), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // First tick after release lands on edge 4.
    strobe(1'b1, 0, 0, 1, 4'b0);
    idle(2);
    check("pre_first_tick", 32'(led[0]), 32'd0);
    cycle();
    check("first_tick", 32'(led[0]), 32'd1);

    repeat (500) begin
      if ($urandom_range(15) == 0) begin
        wren = 1'b1;
        ch_sel = CHW'($urandom_range(5));
        div = DW'($urandom_range(5));
        mode = 2'($urandom_range(3));
      end
      for (int k = 0; k < NCH; k++) clr[k] = ($urandom_range(31) == 0);
      cycle();
      wren = 1'b0;
      clr = '0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/led_cnt_multi.md
# led_cnt_multi

Multi-channel successor to the single LED counter block. NUM_CH independent LED channels share one prescaler on clk100. Each channel has:
- a runtime-programmable tick divider and a mode (off / blink / pulse / solid);
- a saturating event counter and a sticky interrupt flag.

The block sits behind the PL register interface. Software writes one channel's configuration per write strobe and reads event counts back.

## Interface
Parameters:
- NUM_CH, 4, number of LED channels (1..16)
- DIV_W, 12, width of per-channel divider value
- CNT_W, 32, width of per-channel event counter
- PRESCALE, 100000, clk100 cycles per tick (1 ms at 100 MHz); must be >= 2
- DIV_RST, 499, divider value loaded at reset
- CH_W, $clog2(NUM_CH) (min 1), width of channel select (derived)

Ports:
- clk100  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous reset, active-low; one clock, asynchronous active-low reset
- wren_i  in  1  configuration write strobe, one cycle
- ch_sel_i  in  CH_W  channel targeted by wren_i
- div_i  in  DIV_W  divider value written on wren_i
- mode_i  in  2  mode written on wren_i: 00 off, 01 blink, 10 pulse, 11 solid
- int_clr_i  in  NUM_CH  per-channel clear of led_int_o and int_cnt_o
- int_cnt_o  out  NUM_CH*CNT_W  event counters; channel k at bits [k*CNT_W +: CNT_W]
- led_int_o  out  NUM_CH  sticky per-channel event flag
- led_o  out  NUM_CH  LED drive

## Operation
- **Reset:** all outputs 0, prescaler 0, channel counters 0, div_reg = DIV_RST, mode_reg = 01 (blink).
- **Prescaler:**
  - counts 0..PRESCALE-1 and wraps;
  - `tick` is high for the single cycle in which prescaler == PRESCALE-1;
  - free-running and unaffected by writes.
- **Write:** wren_i high with ch_sel_i < NUM_CH loads div_reg[ch_sel_i] <= div_i and mode_reg[ch_sel_i] <= mode_i, and clears that channel's tick counter to 0. led_o, int_cnt_o and led_int_o are unchanged, except that a write with mode 00 clears led_o. A write with ch_sel_i >= NUM_CH is ignored.
- **Channel counter:** advances only on tick and only when mode != 00.
  - If cnt == div_reg: cnt <= 0 and the channel raises an *event*.
  - Otherwise cnt <= cnt+1.
  - The event period is (div_reg+1) ticks. div_reg = 0 gives an event every tick.
- **Modes:**
  - 00 off: cnt held at 0, no events, led_o = 0.
  - 01 blink: led_o toggles on every event.
  - 10 pulse: led_o = 1 exactly while cnt == 0 (one tick of every div_reg+1). With div_reg = 0, led_o is constantly 1.
  - 11 solid: led_o = 1; events still generated.
- **Event accounting:** each event increments int_cnt[k] (saturates at 2^CNT_W-1, no wrap) and sets led_int[k]. led_int[k] stays set until int_clr_i[k].
- **Clear:** int_clr_i[k] sets int_cnt[k] <= 0 and led_int[k] <= 0.
- **Boundary rules:**
  - int_clr_i[k] and an event in the same cycle: int_cnt[k] <= 1, led_int[k] <= 1. Events are never lost.
  - wren_i to channel k in the same cycle as a tick that would produce an event on k: the write wins, cnt <= 0, no event.
  - Lowering div_reg below the current cnt is impossible, because a write always clears cnt.
  - rst_n asserted mid-operation: all state returns to reset values asynchronously. Counting restarts from prescaler 0 after release.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- A tick in cycle T produces the event update (cnt, led_o, int_cnt_o, led_int_o) visible from cycle T+1.
- A write in cycle T takes effect at T+1. The first subsequent event on that channel occurs div_i+1 ticks later.
- int_clr_i in cycle T: cleared values are visible at T+1.
- Channels update in parallel; simultaneous events on several channels are all counted in the same cycle.
- Reset release: the first tick is asserted PRESCALE-1 cycles after the first active clock edge.

## Test plan
Benches use PRESCALE = 4, NUM_CH = 4, CNT_W = 8.

1. **Reset/default:** release rst_n. Required: all outputs 0, tick every 4 clocks. Channel 0 toggles led_o after 500 ticks (2000 clocks), and int_cnt0 = 1.
2. **Blink divider:** write ch1 div=2, mode=01. Required: led_o[1] toggles every 12 clocks; after 5 toggles int_cnt1 = 5 and led_int_o[1] = 1.
3. **Modes:**
   - write ch2 div=3, mode=10: led_o[2] high 4 clocks of every 16;
   - mode=11: led_o[2] = 1 constantly, int_cnt2 still increments;
   - mode=00: led_o[2] = 0 next cycle, int_cnt2 frozen.
4. **Clear collision:** assert int_clr_i[1] in the same cycle as a ch1 event. Required: int_cnt1 = 1, led_int_o[1] = 1. A clear without an event gives 0/0.
5. **Saturation and div=0:** ch3 div=0, mode=01, run 300 ticks. Required: int_cnt3 = 255 held, led_o[3] toggling every 4 clocks.
6. **Write/tick collision and async reset:**
   - write ch1 on the event tick: no event, counter restarts;
   - write ch_sel=5 (with CH_W widened in the test build): no state change;
   - pulse rst_n low mid-count: outputs 0 immediately, without a clock edge.
